// File: rtl/data_mem_ctrl_if.sv
// rtl/data_mem_ctrl_if.sv - request/response channel bundle for data_mem_ctrl
interface data_mem_ctrl_if #(
  parameter int DW = 32
);
  localparam int NB = DW / 8;

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [31:0]   req_addr;
  logic [DW-1:0] req_wdata;
  logic [NB-1:0] req_be;
  logic          par_inj;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, par_inj, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, par_inj, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - single-port word data memory with byte strobes, range check and read latency; optional MEM_PARITY_EN
module data_mem_ctrl #(
  parameter int DW     = 32,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  data_mem_ctrl_if.slave bus
);
  localparam int NB = DW / 8;
  localparam int AW = $clog2(DEPTH);
  // Depth of the read-data delay line; one dummy stage when RD_LAT=1.
  localparam int PL = (RD_LAT > 1) ? RD_LAT - 1 : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [2:0]    r_cnt;
  logic [2:0]    w_cnt_nxt;

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW:0]   r_pipe [PL];
  logic [DW-1:0] r_resp_rdata;
  logic          r_resp_err;

  logic          w_accept;
  logic [AW-1:0] w_idx;
  logic          w_addr_err;
  logic          w_wr_en;
  logic [DW-1:0] w_rd_data;
  logic          w_par_err;
  logic [DW-1:0] w_acc_rdata;
  logic          w_acc_err;

  assign w_accept   = bus.req_valid && (r_state == S_IDLE);
  assign w_idx      = bus.req_addr[AW+1:2];
  assign w_addr_err = (bus.req_addr[1:0] != 2'b00) || ((bus.req_addr >> (AW + 2)) != 32'd0);
  assign w_wr_en    = w_accept && bus.req_we && !w_addr_err;
  assign w_rd_data  = r_mem[w_idx];

  // Writes and errored requests answer with zero data; reads return the raw word.
  assign w_acc_rdata = (bus.req_we || w_addr_err) ? '0 : w_rd_data;
  assign w_acc_err   = w_addr_err || (!bus.req_we && w_par_err);

`ifdef MEM_PARITY_EN
  logic [NB-1:0] r_par [DEPTH];
  logic [NB-1:0] w_par_calc;
  logic [NB-1:0] w_par_new;

  // Recompute parity of the addressed word and build the parity to store on a write.
  always_comb begin
    w_par_calc = '0;
    w_par_new  = '0;
    for (int i = 0; i < NB; i++) begin
      w_par_calc[i] = ^w_rd_data[8*i +: 8];
      w_par_new[i]  = bus.req_be[i] ? ^bus.req_wdata[8*i +: 8] : r_par[w_idx][i];
    end
    w_par_new[0] = w_par_new[0] ^ bus.par_inj;
    w_par_err    = |(w_par_calc ^ r_par[w_idx]);
  end

  // Parity storage follows the data lanes; never reset, like the RAM.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_en) begin
      r_par[w_idx] <= w_par_new;
    end
  end
`else
  logic w_unused;
  assign w_par_err = 1'b0;
  assign w_unused  = bus.par_inj;
`endif

  // RAM array: byte-lane merge on an accepted in-range write; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.req_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
        end
      end
    end
  end

  // FSM state and latency counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: reads with extra latency park in WAIT until the counter hits 1.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (bus.req_we || w_addr_err || (RD_LAT == 1)) begin
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = 3'(RD_LAT - 1);
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 3'd1) begin
          w_state_nxt = S_RESP;
          w_cnt_nxt   = 3'd0;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 3'd0;
      end
    endcase
  end

  // Read-data delay line: captured at accept, shifted one stage per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < PL; k++) begin
        r_pipe[k] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_pipe[0] <= {w_acc_err, w_acc_rdata};
      end
      for (int k = 1; k < PL; k++) begin
        r_pipe[k] <= r_pipe[k-1];
      end
    end
  end

  // Response registers load only on entry to RESP, so they hold under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else if (r_state == S_IDLE && w_state_nxt == S_RESP) begin
      r_resp_rdata <= w_acc_rdata;
      r_resp_err   <= w_acc_err;
    end else if (r_state == S_WAIT && w_state_nxt == S_RESP) begin
      {r_resp_err, r_resp_rdata} <= r_pipe[PL-1];
    end
  end

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - directed self-checking bench for data_mem_ctrl
module tb_data_mem_ctrl;
  localparam int DW     = 32;
  localparam int DEPTH  = 256;
  localparam int RD_LAT = 3;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  int   lat;

  data_mem_ctrl_if #(.DW(DW)) bus ();

  data_mem_ctrl #(.DW(DW), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a request at a negedge and return just after the accepting posedge.
  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input logic inj);
    int n;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    bus.par_inj   = inj;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("req_ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.par_inj   = 1'b0;
  endtask

  // Count negedges from accept until resp_valid; 99 flags an expired bound.
  task automatic wait_resp(output int l);
    l = 1;
    @(negedge clk);
    while (bus.resp_valid !== 1'b1 && l < 20) begin
      @(negedge clk);
      l++;
    end
    if (bus.resp_valid !== 1'b1) l = 99;
  endtask

  task automatic consume;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be, input logic inj,
                      input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err);
    int l;
    send(we, addr, wdata, be, inj);
    wait_resp(l);
    chk({tag, "_lat"}, 64'(l), 64'(exp_lat));
    chk({tag, "_rdata"}, 64'(bus.resp_rdata), 64'(exp_rdata));
    chk({tag, "_err"}, 64'(bus.resp_err), 64'(exp_err));
    consume();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.req_be     = 4'd0;
    bus.par_inj    = 1'b0;
    bus.resp_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_resp_rdata", 64'(bus.resp_rdata), 64'd0);
    chk("rst_resp_err", 64'(bus.resp_err), 64'd0);
    rst = 1'b0;

    // Basic write/read with latency
    xact("t1_wr", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1, 32'h0, 1'b0);
    xact("t1_rd", 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, RD_LAT, 32'hDEADBEEF, 1'b0);

    // Byte-lane strobes and be=0
    xact("t2_wr1", 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, 1, 32'h0, 1'b0);
    xact("t2_wr2", 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, 1, 32'h0, 1'b0);
    xact("t2_rd", 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, RD_LAT, 32'h11BB33DD, 1'b0);
    xact("t2_wr0", 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 1'b0, 1, 32'h0, 1'b0);
    xact("t2_rd0", 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, RD_LAT, 32'h11BB33DD, 1'b0);

    // Address errors and top-of-range word
    xact("t3_mis", 1'b0, 32'h12, 32'h0, 4'h0, 1'b0, 1, 32'h0, 1'b1);
    xact("t3_oor", 1'b0, 32'(DEPTH * 4), 32'h0, 4'h0, 1'b0, 1, 32'h0, 1'b1);
    xact("t3_miswr", 1'b1, 32'h11, 32'h01234567, 4'hF, 1'b0, 1, 32'h0, 1'b1);
    xact("t3_oorwr", 1'b1, 32'h410, 32'h01234567, 4'hF, 1'b0, 1, 32'h0, 1'b1);
    xact("t3_rdback", 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, RD_LAT, 32'hDEADBEEF, 1'b0);
    xact("t3_topwr", 1'b1, 32'h3FC, 32'h87654321, 4'hF, 1'b0, 1, 32'h0, 1'b0);
    xact("t3_toprd", 1'b0, 32'h3FC, 32'h0, 4'h0, 1'b0, RD_LAT, 32'h87654321, 1'b0);

    // Response backpressure with a pending request
    send(1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    wait_resp(lat);
    chk("t4_lat", 64'(lat), 64'(RD_LAT));
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h30;
    bus.req_wdata = 32'h00000077;
    bus.req_be    = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_ready", 64'(bus.req_ready), 64'd0);
      chk("t4_hold_valid", 64'(bus.resp_valid), 64'd1);
      chk("t4_hold_rdata", 64'(bus.resp_rdata), 64'hDEADBEEF);
    end
    consume();
    @(negedge clk);
    chk("t4_post_valid", 64'(bus.resp_valid), 64'd0);
    chk("t4_post_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("t4_wr_valid", 64'(bus.resp_valid), 64'd1);
    chk("t4_wr_rdata", 64'(bus.resp_rdata), 64'd0);
    consume();
    @(negedge clk);
    chk("t4_single_accept", 64'(bus.resp_valid), 64'd0);
    xact("t4_rd", 1'b0, 32'h30, 32'h0, 4'h0, 1'b0, RD_LAT, 32'h00000077, 1'b0);

    // Reset during WAIT
    xact("t5_wr", 1'b1, 32'h40, 32'h5A5A5A5A, 4'hF, 1'b0, 1, 32'h0, 1'b0);
    send(1'b0, 32'h40, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    chk("t5_wait_valid", 64'(bus.resp_valid), 64'd0);
    chk("t5_wait_ready", 64'(bus.req_ready), 64'd0);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 64'(bus.resp_valid), 64'd0);
    chk("t5_rst_ready", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    xact("t5_rd", 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, RD_LAT, 32'h5A5A5A5A, 1'b0);

    // Reset during RESP of a write: the write is still committed
    send(1'b1, 32'h50, 32'hA5A55A5A, 4'hF, 1'b0);
    @(negedge clk);
    chk("t5b_resp_valid", 64'(bus.resp_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("t5b_rst_valid", 64'(bus.resp_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    xact("t5b_rd", 1'b0, 32'h50, 32'h0, 4'h0, 1'b0, RD_LAT, 32'hA5A55A5A, 1'b0);

    // Parity injection
    xact("t6_wr", 1'b1, 32'h60, 32'hCAFEF00D, 4'hF, 1'b1, 1, 32'h0, 1'b0);
`ifdef MEM_PARITY_EN
    xact("t6_rd", 1'b0, 32'h60, 32'h0, 4'h0, 1'b0, RD_LAT, 32'hCAFEF00D, 1'b1);
`else
    xact("t6_rd", 1'b0, 32'h60, 32'h0, 4'h0, 1'b0, RD_LAT, 32'hCAFEF00D, 1'b0);
`endif
    xact("t6_clean", 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, RD_LAT, 32'hDEADBEEF, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
